// File: rtl/bsg_nonsynth_latency_sampler.sv
// bsg_nonsynth_latency_sampler
//
// Measures request-to-response latency, in cycles, for an in-order stream.
// Every accepted request records the current value of a free-running cycle
// counter in a small circular queue. Every response retires the oldest
// request. One cycle after the response, the block emits one valid/value
// sample. The sample is the elapsed time, coarsened by a right shift and
// then saturated to the sample width.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   clear_i      synchronous flush of queue and sticky flags (wins over req/resp)
//   req_v_i      a request is issued this cycle
//   resp_v_i     the oldest outstanding request completes this cycle
//   v_o          registered sample valid (one cycle after a successful dequeue)
//   val_o        registered latency sample; holds while v_o is low
//   count_o      number of outstanding requests
//   full_o       count_o == els_p
//   drop_o       sticky: a request arrived while the queue was full
//   underflow_o  sticky: a response arrived while the queue was empty
module bsg_nonsynth_latency_sampler #(
  parameter int els_p         = 8,
  parameter int stamp_width_p = 16,
  parameter int shift_p       = 0,
  parameter int val_width_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clear_i,
  input  logic                         req_v_i,
  input  logic                         resp_v_i,
  output logic                         v_o,
  output logic [val_width_p-1:0]       val_o,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         drop_o,
  output logic                         underflow_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  // Compare in a width that holds both the coarsened latency and the
  // saturation limit. This keeps saturation correct whichever width is larger.
  localparam int cmp_w = ((stamp_width_p > val_width_p) ? stamp_width_p : val_width_p) + 1;
  localparam logic [cnt_w-1:0] els_lp = cnt_w'(els_p);
  localparam logic [cmp_w-1:0] sat_lp = cmp_w'({val_width_p{1'b1}});

  logic [stamp_width_p-1:0] now_r;
  logic [stamp_width_p-1:0] stamp_mem [els_p];
  logic [ptr_w-1:0]         rd_ptr_r;
  logic [ptr_w-1:0]         wr_ptr_r;
  logic [cnt_w-1:0]         count_r;

  logic                     empty;
  logic                     full;
  logic                     deq;
  logic                     enq;
  logic [stamp_width_p-1:0] raw;
  logic [cmp_w-1:0]         coarse;
  logic [val_width_p-1:0]   sample;

  // Full and empty come from the occupancy count, because equal pointers
  // are ambiguous. A dequeue frees a slot in the same cycle, so a full
  // queue still accepts a request that comes with a response. There is
  // no bypass: an empty queue never answers a response in the same cycle.
  always_comb begin
    empty  = (count_r == '0);
    full   = (count_r == els_lp);
    deq    = resp_v_i && !clear_i && !empty;
    enq    = req_v_i && !clear_i && (!full || deq);
    raw    = now_r - stamp_mem[rd_ptr_r];
    coarse = cmp_w'(raw >> shift_p);
    sample = (coarse > sat_lp) ? '1 : coarse[val_width_p-1:0];
  end

  // The free-running timestamp counter wraps naturally. clear_i does not
  // affect it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      now_r <= '0;
    end else begin
      now_r <= now_r + stamp_width_p'(1);
    end
  end

  // Stamp storage needs no reset. Reset and clear both empty the queue,
  // so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      stamp_mem[wr_ptr_r] <= now_r;
    end
  end

  // Queue bookkeeping, sample output and sticky error flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      v_o         <= 1'b0;
      val_o       <= '0;
      drop_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      v_o         <= 1'b0;
      drop_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      v_o <= deq;
      if (deq) begin
        val_o    <= sample;
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end
      if (enq) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
      if (req_v_i && full && !deq) begin
        drop_o <= 1'b1;
      end
      if (resp_v_i && empty) begin
        underflow_o <= 1'b1;
      end
    end
  end

  assign count_o = count_r;
  assign full_o  = full;

  // Occupancy can never exceed the queue depth.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) count_r <= els_lp);

endmodule

// File: tb/tb_bsg_nonsynth_latency_sampler.sv
// Testbench for bsg_nonsynth_latency_sampler.
// The reference model keeps the absolute issue cycle of every outstanding
// request in a queue. It derives each sample from the elapsed cycle count
// using plain arithmetic.
module tb_bsg_nonsynth_latency_sampler;

  localparam int ElsP   = 8;
  localparam int StampW = 8;
  localparam int ShiftP = 2;
  localparam int ValW   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       req = 1'b0;
  logic       resp = 1'b0;
  logic       v;
  logic [3:0] val;
  logic [3:0] count;
  logic       full;
  logic       drop;
  logic       underflow;

  bsg_nonsynth_latency_sampler #(
    .els_p(ElsP), .stamp_width_p(StampW), .shift_p(ShiftP), .val_width_p(ValW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .req_v_i(req),
    .resp_v_i(resp), .v_o(v), .val_o(val), .count_o(count), .full_o(full),
    .drop_o(drop), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int q[$];
  int t;
  bit expDrop, expUf, expV;
  int expVal;

  // Count one comparison and report it if it miscompares.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    t = 0;
    expDrop = 0;
    expUf = 0;
    expV = 0;
    expVal = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelEdge(input bit r, input bit s, input bit c);
    int pre;
    bit did;
    int lat;
    pre = q.size();
    if (c) begin
      q.delete();
      expDrop = 0;
      expUf = 0;
      expV = 0;
    end else begin
      did = s && pre > 0;
      if (s && pre == 0) expUf = 1;
      expV = did;
      if (did) begin
        lat = (t - q[0]) % (1 << StampW);
        lat = lat >> ShiftP;
        expVal = (lat > (1 << ValW) - 1) ? (1 << ValW) - 1 : lat;
        void'(q.pop_front());
      end
      if (r) begin
        if (pre < ElsP || did) q.push_back(t);
        else expDrop = 1;
      end
    end
    t++;
  endtask

  task automatic checkAll();
    checkOutput("v_o", int'(v), int'(expV));
    checkOutput("val_o", int'(val), expVal);
    checkOutput("count_o", int'(count), q.size());
    checkOutput("full_o", int'(full), int'(q.size() == ElsP));
    checkOutput("drop_o", int'(drop), int'(expDrop));
    checkOutput("underflow_o", int'(underflow), int'(expUf));
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit c);
    @(negedge clk);
    req = r;
    resp = s;
    clear = c;
    @(posedge clk);
    modelEdge(r, s, c);
    #1 checkAll();
  endtask

  // Assert reset between clock edges and check that the outputs drop
  // immediately. Then hold reset across one edge and release it.
  task automatic resetPulse();
    @(negedge clk);
    req = 1'b1;
    resp = 1'b1;
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    req = 1'b0;
    resp = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #12 checkAll();
    @(negedge clk);
    reset_n = 1'b1;

    // Request at cycle 10, response at cycle 13: latency 3 coarsens to 0.
    repeat (10) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Latency 70 saturates to 15, latency 9 gives 2, latency 300 aliases to 44 and gives 11.
    applyStimulus(1, 0, 0);
    repeat (69) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    repeat (8) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    repeat (299) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);

    // Fill the queue, drop one request, then do req+resp while full, then drain.
    repeat (9) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (8) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    repeat (8) applyStimulus(0, 1, 0);

    // Underflow when empty, then req+resp together when empty.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);

    // Sliding window: requests every 2 cycles, each answered 5 cycles later.
    for (int c = 0; c < 46; c++)
      applyStimulus(c % 2 == 0 && c < 40, c >= 5 && (c - 5) % 2 == 0 && c < 45, 0);

    // Clear with 4 outstanding and a concurrent req/resp.
    repeat (4) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);

    // Async reset in the middle of a burst, then respond to a stale request.
    repeat (3) applyStimulus(1, 0, 0);
    resetPulse();
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 60) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_nonsynth_latency_sampler.md
Name: bsg_nonsynth_latency_sampler

Overview:
- Measures request-to-response latency, in cycles, for an in-order transaction stream.
- Emits one valid/value sample per retired request, one cycle after the response.
- Sits directly upstream of the histogram profiler client: v_o/val_o connect straight to its v_i/val_i.
- Timestamps of outstanding requests are held in a small circular queue.

Parameters:
- els_p, 8: maximum outstanding requests (queue depth); must be a power of 2, at least 2.
- stamp_width_p, 16: width of the free-running cycle counter and the stored timestamps.
- shift_p, 0: right-shift applied to the raw latency (bucket coarsening) before saturation.
- val_width_p, 4: width of the emitted sample; it feeds the histogram's val_i.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: reset, asynchronous, active-low.
- clear_i, input, 1: synchronous flush of the queue and the sticky flags.
- req_v_i, input, 1: a request is issued this cycle.
- resp_v_i, input, 1: the oldest outstanding request completes this cycle.
- v_o, output, 1: sample valid, registered.
- val_o, output, val_width_p: latency sample, registered.
- count_o, output, clog2(els_p+1): number of outstanding requests.
- full_o, output, 1: count_o == els_p.
- drop_o, output, 1: sticky; a request arrived while the queue was full.
- underflow_o, output, 1: sticky; a response arrived while the queue was empty.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - now counter = 0; read and write pointers = 0; count_o = 0.
  - v_o = 0, val_o = 0, full_o = 0, drop_o = 0, underflow_o = 0.
- Timestamp counter "now": increments every cycle and wraps modulo 2^stamp_width_p.
- Enqueue:
  - When req_v_i=1 and the queue is not full at the start of the cycle, store "now" at the write pointer and advance the pointer.
  - A request issued in cycle t therefore records stamp t.
- Dequeue:
  - When resp_v_i=1 and count>0 at the start of the cycle:
    - raw = (now - stamp[rd]) mod 2^stamp_width_p
    - b = raw >> shift_p
    - val_o <= min(b, 2^val_width_p - 1), i.e. saturating.
  - Advance the read pointer and set v_o <= 1 in the next cycle.
- v_o is 0 in every cycle that does not follow a successful dequeue. The sample latency is exactly 1 cycle after resp_v_i.
- val_o holds its last value while v_o=0.
- Latency values:
  - Minimum measurable latency is 1: the response comes in a later cycle than its request.
  - Latencies at or above 2^stamp_width_p alias modulo that value. This is documented, not flagged.
- Simultaneous req_v_i and resp_v_i:
  - Empty queue: the request is enqueued, the response is an underflow (no bypass). underflow_o is set, no sample is produced, and count becomes 1.
  - Full queue: both are accepted (the dequeue frees a slot in the same cycle). count stays els_p and drop_o is not set.
  - Otherwise: both are accepted and count is unchanged.
- Full, req only: the request is discarded, drop_o is set sticky, and pointers are unchanged.
- Empty, resp only: underflow_o is set sticky; pointers and v_o are unaffected.
- Pointer wrap: both pointers wrap modulo els_p. Full versus empty is distinguished by count, not by pointer equality.
- clear_i:
  - Has priority over same-cycle req_v_i and resp_v_i, which are ignored in that cycle.
  - Next cycle: pointers = 0, count = 0, drop_o = 0, underflow_o = 0, v_o = 0.
  - The now counter is NOT cleared.
- Reset asserted mid-operation discards all outstanding stamps immediately. Responses to requests issued before reset then register as underflow.
- Sticky flags are cleared only by reset or clear_i.
- Sanity check: an assertion fires if count exceeds els_p.

Test Plan:
1. Reset release, req in cycle 10, resp in cycle 13 -> v_o=1 in cycle 14 with val_o=3; count_o returns to 0.
2. shift_p=2, val_width_p=4, latency 70 -> b=17, saturates, val_o=15. Latency 9 -> val_o=2.
3. els_p=8: issue 9 back-to-back requests -> full_o=1 after the 8th, the 9th sets drop_o. Then req+resp together while full -> count stays 8, drop_o not newly set.
4. resp_v_i with count 0 -> underflow_o=1, v_o stays 0. req+resp together when empty -> count_o=1, underflow_o=1.
5. Pointer wrap: 20 requests with fixed latency 5, issued in a sliding window of 3 outstanding -> 20 samples, all val_o=5, samples in order.
6. clear_i with 4 outstanding plus concurrent req/resp -> next cycle count_o=0, flags 0, no sample. Async reset pulse mid-burst -> all outputs 0 immediately, before the next clock edge.
